// File: rtl/opsum_post_proc.sv
// opsum_post_proc: post-processing between the conv_unit opsum FIFO and the GLB.
// For each 32-bit psum it adds an optional bias, applies an optional ReLU, and
// requantizes to int8 (multiply, round-half-up right shift, saturate). Four int8
// results are packed little-endian into one 32-bit word. Each word is written to
// consecutive GLB word addresses.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start_i               1-cycle pulse; latches the config and starts a pass (only in IDLE)
//   base_addr_i, total_i  first GLB word address; number of psums in the pass
//   bias_en_i, bias_i     optional signed bias added to every psum
//   relu_en_i             clamp negative sums to zero before requantization
//   mult_i, shift_i       requant multiplier (unsigned) and rounding right shift
//   opsum_valid_i/_data_i psum stream from the opsum FIFO
//   opsum_ready_o         pop strobe; a transfer happens when valid & ready
//   glb_grant_i           GLB accepts the presented write this cycle
//   glb_web_o             byte write enables, active-low (4'hF = idle)
//   glb_addr_o            GLB word address
//   glb_write_data_o      packed int8 x4; lane k is bits [8k+7:8k]
//   busy_o, done_o        pass in progress; 1-cycle end-of-pass pulse
module opsum_post_proc #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MULT_W  = 16,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic [15:0]        total_i,
    input  logic               bias_en_i,
    input  logic [DATA_W-1:0]  bias_i,
    input  logic               relu_en_i,
    input  logic [MULT_W-1:0]  mult_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               opsum_valid_i,
    input  logic [DATA_W-1:0]  opsum_data_i,
    output logic               opsum_ready_o,
    input  logic               glb_grant_i,
    output logic [3:0]         glb_web_o,
    output logic [ADDR_W-1:0]  glb_addr_o,
    output logic [DATA_W-1:0]  glb_write_data_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned PROD_W = DATA_W + MULT_W + 2;
    localparam logic signed [PROD_W-1:0] QMAX = 127;
    localparam logic signed [PROD_W-1:0] QMIN = -128;

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e state_q, state_d;

    // Pass configuration, latched on start
    logic [ADDR_W-1:0]  base_q;
    logic [15:0]        total_q;
    logic               bias_en_q, relu_en_q;
    logic [DATA_W-1:0]  bias_q;
    logic [MULT_W-1:0]  mult_q;
    logic [SHIFT_W-1:0] shift_q;

    logic [15:0]        in_cnt_q, out_cnt_q, word_cnt_q;
    logic               s1_valid_q, s2_valid_q;
    logic signed [DATA_W:0] s1_sum_q;
    logic [7:0]         s2_q_q;
    logic [DATA_W-1:0]  pack_q;

    logic                    pending, stall, accept, start_ok;
    logic signed [DATA_W:0]  sum_d;
    logic signed [PROD_W-1:0] prod, rnd, r;
    logic [7:0]              q_d;
    logic [1:0]              lane;
    logic                    last, pack_en, fire;
    logic [DATA_W-1:0]       word_d;
    logic [3:0]              web_d;

    // Datapath and handshake
    always_comb begin
        pending       = (glb_web_o != 4'hF);
        stall         = pending & ~glb_grant_i;
        opsum_ready_o = (state_q == StRun) && (in_cnt_q < total_q) && !stall;
        accept        = opsum_valid_i & opsum_ready_o;
        start_ok      = (state_q == StIdle) && start_i;

        sum_d = {opsum_data_i[DATA_W-1], opsum_data_i}
              + (bias_en_q ? {bias_q[DATA_W-1], bias_q} : '0);
        if (relu_en_q && sum_d[DATA_W]) sum_d = '0;

        prod = PROD_W'(s1_sum_q) * PROD_W'($signed({1'b0, mult_q}));
        rnd  = (shift_q == '0) ? '0 : (PROD_W'(1) << (shift_q - SHIFT_W'(1)));
        r    = (prod + rnd) >>> shift_q;
        if (r > QMAX)      q_d = 8'h7F;
        else if (r < QMIN) q_d = 8'h80;
        else               q_d = r[7:0];

        lane    = out_cnt_q[1:0];
        last    = (out_cnt_q == total_q - 16'd1);
        pack_en = s2_valid_q & ~stall;
        fire    = pack_en & ((lane == 2'd3) | last);
        word_d  = pack_q | (DATA_W'(s2_q_q) << {lane, 3'b000});
        // Active-low enables for lanes 0..lane
        unique case (lane)
            2'd0:    web_d = 4'b1110;
            2'd1:    web_d = 4'b1100;
            2'd2:    web_d = 4'b1000;
            default: web_d = 4'b0000;
        endcase
    end

    // Next-state and status outputs
    always_comb begin
        state_d = state_q;
        busy_o  = (state_q == StRun) || (state_q == StFlush);
        done_o  = (state_q == StDone);
        unique case (state_q)
            StIdle:  if (start_i) state_d = (total_i == '0) ? StDone : StRun;
            StRun:   if (in_cnt_q == total_q) state_d = StFlush;
            StFlush: if (!s1_valid_q && !s2_valid_q && !pending) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            base_q           <= '0;
            total_q          <= '0;
            bias_en_q        <= 1'b0;
            relu_en_q        <= 1'b0;
            bias_q           <= '0;
            mult_q           <= '0;
            shift_q          <= '0;
            in_cnt_q         <= '0;
            out_cnt_q        <= '0;
            word_cnt_q       <= '0;
            s1_valid_q       <= 1'b0;
            s2_valid_q       <= 1'b0;
            s1_sum_q         <= '0;
            s2_q_q           <= '0;
            pack_q           <= '0;
            glb_web_o        <= 4'hF;
            glb_addr_o       <= '0;
            glb_write_data_o <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q     <= base_addr_i;
                total_q    <= total_i;
                bias_en_q  <= bias_en_i;
                relu_en_q  <= relu_en_i;
                bias_q     <= bias_i;
                mult_q     <= mult_i;
                shift_q    <= shift_i;
                in_cnt_q   <= '0;
                out_cnt_q  <= '0;
                word_cnt_q <= '0;
                pack_q     <= '0;
            end
            if (accept) in_cnt_q <= in_cnt_q + 16'd1;
            // Whole pipe freezes while a presented write waits for grant
            if (!stall) begin
                s1_valid_q <= accept;
                s1_sum_q   <= sum_d;
                s2_valid_q <= s1_valid_q;
                s2_q_q     <= q_d;
            end
            if (pack_en) begin
                out_cnt_q <= out_cnt_q + 16'd1;
                pack_q    <= fire ? '0 : word_d;
            end
            // A new word may replace one being granted in the same cycle
            if (fire) begin
                glb_web_o        <= web_d;
                glb_addr_o       <= base_q + ADDR_W'(word_cnt_q);
                glb_write_data_o <= word_d;
                word_cnt_q       <= word_cnt_q + 16'd1;
            end else if (pending && glb_grant_i) begin
                glb_web_o <= 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_opsum_post_proc.sv
// Directed self-checking bench for opsum_post_proc.
module tb_opsum_post_proc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] total_i;
    logic        bias_en_i;
    logic [31:0] bias_i;
    logic        relu_en_i;
    logic [15:0] mult_i;
    logic [4:0]  shift_i;
    logic        opsum_valid_i;
    logic [31:0] opsum_data_i;
    logic        opsum_ready_o;
    logic        glb_grant_i;
    logic [3:0]  glb_web_o;
    logic [31:0] glb_addr_o;
    logic [31:0] glb_write_data_o;
    logic        busy_o;
    logic        done_o;

    opsum_post_proc dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .base_addr_i      (base_addr_i),
        .total_i          (total_i),
        .bias_en_i        (bias_en_i),
        .bias_i           (bias_i),
        .relu_en_i        (relu_en_i),
        .mult_i           (mult_i),
        .shift_i          (shift_i),
        .opsum_valid_i    (opsum_valid_i),
        .opsum_data_i     (opsum_data_i),
        .opsum_ready_o    (opsum_ready_o),
        .glb_grant_i      (glb_grant_i),
        .glb_web_o        (glb_web_o),
        .glb_addr_o       (glb_addr_o),
        .glb_write_data_o (glb_write_data_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int stall_cycles = 0;
    int block_cnt = 0;
    int psum [8];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] wr_web  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // GLB model: drives grant, logs granted writes, counts done pulses
    initial begin
        glb_grant_i = 1'b1;
        forever begin
            @(negedge clk);
            if (block_cnt > 0 && glb_web_o != 4'hF) begin
                glb_grant_i = 1'b0;
                block_cnt--;
            end else begin
                glb_grant_i = 1'b1;
            end
            #1;
            if (rst_n) begin
                if (glb_web_o != 4'hF && glb_grant_i) begin
                    wr_addr.push_back(glb_addr_o);
                    wr_data.push_back(glb_write_data_o);
                    wr_web.push_back({28'h0, glb_web_o});
                end
                if (glb_web_o != 4'hF && !glb_grant_i) begin
                    stall_cycles++;
                    chk("ready_low_in_stall", {31'h0, opsum_ready_o}, 32'h0);
                end
                if (done_o) done_cnt++;
            end
        end
    end

    task automatic do_start(input int t, input logic [31:0] base, input logic be,
                            input int b, input logic re, input int m, input int s);
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        wr_web.delete();
        done_cnt     = 0;
        stall_cycles = 0;
        total_i      = 16'(t);
        base_addr_i  = base;
        bias_en_i    = be;
        bias_i       = b;
        relu_en_i    = re;
        mult_i       = 16'(m);
        shift_i      = 5'(s);
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic feed(input int n);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 300) begin
            @(negedge clk);
            opsum_valid_i = 1'b1;
            opsum_data_i  = psum[idx];
            #2;
            if (opsum_ready_o) idx++;
            cyc++;
        end
        @(negedge clk);
        opsum_valid_i = 1'b0;
        chk("feed_complete", idx, n);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk(tag, done_cnt, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'h0, opsum_ready_o}, 32'h0);
        chk({tag, "_web"},   {28'h0, glb_web_o},     32'hF);
        chk({tag, "_addr"},  glb_addr_o,             32'h0);
        chk({tag, "_data"},  glb_write_data_o,       32'h0);
        chk({tag, "_busy"},  {31'h0, busy_o},        32'h0);
        chk({tag, "_done"},  {31'h0, done_o},        32'h0);
    endtask

    task automatic run_t1(input string tag);
        for (int i = 0; i < 8; i++) psum[i] = i + 1;
        do_start(8, 32'h3000, 1'b0, 0, 1'b0, 1, 0);
        chk({tag, "_busy"}, {31'h0, busy_o}, 32'h1);
        feed(8);
        wait_done({tag, "_done_pulse"});
        chk({tag, "_nwr"},   wr_data.size(), 2);
        chk({tag, "_addr0"}, wr_addr[0], 32'h3000);
        chk({tag, "_data0"}, wr_data[0], 32'h04030201);
        chk({tag, "_web0"},  wr_web[0],  32'h0);
        chk({tag, "_addr1"}, wr_addr[1], 32'h3001);
        chk({tag, "_data1"}, wr_data[1], 32'h08070605);
        chk({tag, "_web1"},  wr_web[1],  32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        base_addr_i = '0;
        total_i = '0;
        bias_en_i = 1'b0;
        bias_i = '0;
        relu_en_i = 1'b0;
        mult_i = '0;
        shift_i = '0;
        opsum_valid_i = 1'b0;
        opsum_data_i = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain packing of 1..8
        run_t1("t1");

        // Bias -10 then ReLU, saturation at +127
        psum[0] = 5; psum[1] = 20; psum[2] = 300; psum[3] = -400;
        do_start(4, 32'h100, 1'b1, -10, 1'b1, 1, 0);
        feed(4);
        wait_done("t2_done_pulse");
        chk("t2_nwr",  wr_data.size(), 1);
        chk("t2_data", wr_data[0], 32'h007F0A00);
        chk("t2_web",  wr_web[0],  32'h0);

        // mult 3, shift 2: rounding of negatives and saturation
        psum[0] = 1; psum[1] = 2; psum[2] = -3; psum[3] = 1000;
        do_start(4, 32'h200, 1'b0, 0, 1'b0, 3, 2);
        feed(4);
        wait_done("t3_done_pulse");
        chk("t3_data", wr_data[0], 32'h7FFE0201);

        // Grant withheld 5 cycles on the first word; partial last word
        for (int i = 0; i < 6; i++) psum[i] = i + 1;
        block_cnt = 5;
        do_start(6, 32'h400, 1'b0, 0, 1'b0, 1, 0);
        feed(6);
        wait_done("t4_done_pulse");
        chk("t4_stall_cycles", stall_cycles, 5);
        chk("t4_nwr",   wr_data.size(), 2);
        chk("t4_addr0", wr_addr[0], 32'h400);
        chk("t4_data0", wr_data[0], 32'h04030201);
        chk("t4_addr1", wr_addr[1], 32'h401);
        chk("t4_data1", wr_data[1], 32'h00000605);
        chk("t4_web1",  wr_web[1],  32'hC);

        // total = 0: straight to done, no write
        do_start(0, 32'h500, 1'b0, 0, 1'b0, 1, 0);
        #1;
        chk("t5_zero_done", {31'h0, done_o}, 32'h1);
        repeat (4) @(negedge clk);
        chk("t5_zero_nwr",  wr_data.size(), 0);
        chk("t5_zero_ndone", done_cnt, 1);

        // start while busy must be ignored
        for (int i = 0; i < 4; i++) psum[i] = i + 9;
        do_start(4, 32'h5000, 1'b0, 0, 1'b0, 1, 0);
        @(negedge clk);
        total_i = 16'd1;
        base_addr_i = 32'h6000;
        mult_i = 16'd2;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        feed(4);
        wait_done("t5_busy_done_pulse");
        chk("t5_busy_nwr",  wr_data.size(), 1);
        chk("t5_busy_addr", wr_addr[0], 32'h5000);
        chk("t5_busy_data", wr_data[0], 32'h0C0B0A09);

        // Asynchronous reset mid-pass, then a clean rerun
        for (int i = 0; i < 8; i++) psum[i] = i + 1;
        do_start(8, 32'h3000, 1'b0, 0, 1'b0, 1, 0);
        feed(3);
        chk("t6_busy_before", {31'h0, busy_o}, 32'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        run_t1("t6_rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
